// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        onehot = NUM_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after ptr, wrapping, ptr itself last.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // k = NUM_REQ wraps the index back onto ptr, giving the last winner lowest priority
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a 4:1 data mux with burst-held grants and valid/ready output.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module rr_mux4_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  last,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   c,
    input  logic [DATA_W-1:0]   d,
    input  logic                out_ready,
    output logic [NUM_REQ-1:0]  gnt,
    output logic                s0,
    output logic                s1,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic [NUM_REQ-1:0]  rdy,
    output logic                wdog_abort
);

    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    sel, sel_nxt;
    logic [SEL_W-1:0]    ptr, ptr_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [SEL_W-1:0]    winner;
    logic                any;
    logic                xfer;
    logic                stall_out;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    assign {s1, s0}  = sel;
    assign out_valid = (state == GRANT) && req[sel];
    assign out_last  = out_valid && last[sel];
    assign xfer      = out_valid && out_ready;
    assign rdy       = gnt & {NUM_REQ{out_ready}};

    always_comb begin
        out_data = a;
        unique case (sel)
            2'd0: out_data = a;
            2'd1: out_data = b;
            2'd2: out_data = c;
            2'd3: out_data = d;
        endcase
    end

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned         WCNT_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WCNT_W-1:0]   WCNT_MAX = WCNT_W'(WDOG_CYCLES - 1);

    logic [WCNT_W-1:0] wcnt, wcnt_nxt;

    assign stall_out = (state == GRANT) && !xfer && (wcnt == WCNT_MAX);

    // Held at zero while idle, so the count starts clean on entering GRANT
    always_comb begin
        wcnt_nxt = wcnt;
        if (state == IDLE || xfer)
            wcnt_nxt = '0;
        else
            wcnt_nxt = wcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wcnt       <= wcnt_nxt;
            wdog_abort <= stall_out;
        end
    end
`else
    assign stall_out  = 1'b0;
    assign wdog_abort = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        if (state == IDLE) begin
            if (any) begin
                state_nxt = GRANT;
                gnt_nxt   = onehot(winner);
                sel_nxt   = winner;
                ptr_nxt   = winner;
            end
        end else begin
            if ((xfer && out_last) || stall_out) begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= SEL_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule
